// File: rtl/n_term_pkg.sv
// Shared types and constants for the north-edge terminal bridge.
package n_term_pkg;

    localparam int unsigned NUM_WIRES      = 12;
    localparam int unsigned SNAP_DEPTH_DEF = 4;

    // Bit positions of the named northbound wires
    localparam int unsigned W_A0 = 0;
    localparam int unsigned W_B0 = 1;
    localparam int unsigned W_C0 = 2;
    localparam int unsigned W_D0 = 3;
    localparam int unsigned W_F0 = 4;
    localparam int unsigned W_G0 = 5;
    localparam int unsigned W_G1 = 6;
    localparam int unsigned W_H0 = 7;
    localparam int unsigned W_H1 = 8;
    localparam int unsigned W_I0 = 9;
    localparam int unsigned W_I1 = 10;
    localparam int unsigned W_I2 = 11;

    typedef logic [NUM_WIRES-1:0] snap_word_t;

endpackage

// File: rtl/n_term_edge_bridge_if.sv
// Valid/ready snapshot reader port of the north-edge bridge.
interface n_term_edge_bridge_if;

    n_term_pkg::snap_word_t snap_data;
    logic                   snap_valid;
    logic                   snap_ready;

    modport master (output snap_data, output snap_valid, input snap_ready);
    modport slave  (input snap_data, input snap_valid, output snap_ready);

endinterface

// File: rtl/n_term_snap_fifo.sv
// Synchronous FIFO without fall-through; caller guarantees legal push/pop.
module n_term_snap_fifo #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_c_o,
    output logic                     empty_c_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;

    always_comb begin
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    // Storage needs no reset: it is only visible through a non-empty head
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign empty_c_o = (count_q == '0);
    assign rdata_c_o = empty_c_o ? '0 : mem_q[rd_ptr_q];
    assign count_o   = count_q;

endmodule

// File: rtl/n_term_edge_bridge.sv
// North-edge terminal bridge: per-wire comb/registered loopback plus snapshot FIFO.
module n_term_edge_bridge
    import n_term_pkg::*;
#(
    parameter int unsigned SNAP_DEPTH = SNAP_DEPTH_DEF
) (
    input  logic                        UserCLK,
    input  logic                        reset,
    input  snap_word_t                  from_N,
    output snap_word_t                  to_S,
    input  logic                        cfg_shift_en,
    input  logic                        cfg_shift_in,
    output logic                        cfg_shift_out,
    input  logic                        cfg_commit,
    input  logic                        snap_req,
    n_term_edge_bridge_if.master        snap,
    output logic                        snap_overflow,
    input  logic                        snap_ovf_clr
);

    localparam int unsigned CW = $clog2(SNAP_DEPTH) + 1;

    snap_word_t     shadow_q;
    snap_word_t     active_q;
    snap_word_t     pipe_q;
    logic           ovf_q;
    logic           ovf_d;
    logic           fifo_empty;
    logic           fifo_full;
    logic [CW-1:0]  fifo_count;
    logic           push;
    logic           pop;

    assign fifo_full = (fifo_count == CW'(SNAP_DEPTH));
    assign pop       = snap.snap_valid & snap.snap_ready;
    assign push      = snap_req & (~fifo_full | pop);

    // A new drop beats a simultaneous clear
    always_comb begin
        ovf_d = ovf_q;
        if (snap_ovf_clr)                  ovf_d = 1'b0;
        if (snap_req & fifo_full & ~pop)   ovf_d = 1'b1;
    end

    // Commit samples the pre-shift shadow when both happen together
    always_ff @(posedge UserCLK or posedge reset) begin
        if (reset) begin
            shadow_q <= '0;
            active_q <= '0;
            pipe_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (cfg_shift_en) shadow_q <= {shadow_q[NUM_WIRES-2:0], cfg_shift_in};
            if (cfg_commit)   active_q <= shadow_q;
            pipe_q <= from_N;
            ovf_q  <= ovf_d;
        end
    end

    n_term_snap_fifo #(
        .WIDTH (NUM_WIRES),
        .DEPTH (SNAP_DEPTH)
    ) u_snap_fifo (
        .clk       (UserCLK),
        .rst       (reset),
        .push_i    (push),
        .pop_i     (pop),
        .wdata_i   (from_N),
        .rdata_c_o (snap.snap_data),
        .empty_c_o (fifo_empty),
        .count_o   (fifo_count)
    );

    assign snap.snap_valid = ~fifo_empty;
    assign to_S            = (active_q & pipe_q) | (~active_q & from_N);
    assign cfg_shift_out   = shadow_q[NUM_WIRES-1];
    assign snap_overflow   = ovf_q;

endmodule
